ez8_prog_loader: RTL

//  Writer side of the ez8_cpu instruction-load port. Accepts a framed byte stream (valid/ready),

---
 rtl/ez8_prog_loader_if.sv | 22 ++
 rtl/ez8_prog_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ez8_prog_loader_if.sv
// Byte-stream and instruction-write bus between the host link, the program loader and ez8_cpu.
// The loader drives the master side; the host byte source and the instruction memory see the slave side.
interface ez8_prog_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] instr_writeaddr;
  logic [15:0]           instr_writedata;
  logic                  instr_write_en;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, instr_writeaddr, instr_writedata, instr_write_en
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, instr_writeaddr, instr_writedata, instr_write_en
  );
endinterface

// File: rtl/ez8_prog_loader.sv
// Framed program loader for ez8_cpu: assembles big-endian instruction words from a byte stream,
// writes them to instruction memory and keeps the CPU paused until the frame checksum verifies.
module ez8_prog_loader #(
  parameter int       ADDR_WIDTH     = 12,
  parameter bit [7:0] SYNC_BYTE      = 8'hA5,
  parameter int       TIMEOUT_CYCLES = 50000,
  parameter bit       PAUSE_AT_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  ez8_prog_loader_if.master  bus,
  output logic               cpu_pause,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
    S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam int unsigned CNT_MAX = 32'd1 << ADDR_WIDTH;

  state_t                state_reg, state_next;
  logic [7:0]            sum_reg, sum_next;
  logic [7:0]            hi_reg, hi_next;
  logic [15:0]           cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [15:0]           wdata_reg, wdata_next;
  logic                  wr_en_reg, wr_en_next;
  logic                  pause_reg, pause_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic [TW-1:0]         tmo_reg, tmo_next;

  logic        accept;
  logic        busy;
  logic [15:0] cnt_val;

  // The write-strobe cycle is the only stall; it gives the address increment a free slot.
  assign bus.rx_ready        = ~wr_en_reg;
  assign accept              = bus.rx_valid & ~wr_en_reg;
  assign busy                = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_ERR);
  assign cnt_val             = {cnt_reg[15:8], bus.rx_data};

  assign bus.instr_writeaddr = addr_reg;
  assign bus.instr_writedata = wdata_reg;
  assign bus.instr_write_en  = wr_en_reg;
  assign cpu_pause           = pause_reg;
  assign load_busy           = busy;
  assign load_done           = done_reg;
  assign load_error          = err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      sum_reg   <= '0;
      hi_reg    <= '0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wr_en_reg <= 1'b0;
      pause_reg <= PAUSE_AT_RESET;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      hi_reg    <= hi_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wr_en_reg <= wr_en_next;
      pause_reg <= pause_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sum_next   = sum_reg;
    hi_next    = hi_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wr_en_next = 1'b0;
    pause_next = pause_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    tmo_next   = '0;

    if (wr_en_reg)
      addr_next = addr_reg + ADDR_WIDTH'(1);
    if (busy && !accept)
      tmo_next = tmo_reg + TW'(1);
    if (busy && accept && state_reg != S_CSUM)
      sum_next = sum_reg + bus.rx_data;

    if (accept) begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_next = S_ADDR_HI;
            sum_next   = '0;
            done_next  = 1'b0;
            err_next   = 1'b0;
            pause_next = 1'b1;
          end
        end
        S_ADDR_HI: begin
          hi_next    = bus.rx_data;
          state_next = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_next  = ADDR_WIDTH'({hi_reg, bus.rx_data});
          state_next = S_CNT_HI;
        end
        S_CNT_HI: begin
          cnt_next   = {bus.rx_data, 8'h00};
          state_next = S_CNT_LO;
        end
        S_CNT_LO: begin
          cnt_next = cnt_val;
          if (cnt_val == 16'd0) begin
            state_next = S_CSUM;
          end else if (32'(cnt_val) > CNT_MAX) begin
            state_next = S_ERR;
            err_next   = 1'b1;
          end else begin
            state_next = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          hi_next    = bus.rx_data;
          state_next = S_DATA_LO;
        end
        S_DATA_LO: begin
          wdata_next = {hi_reg, bus.rx_data};
          wr_en_next = 1'b1;
          cnt_next   = cnt_reg - 16'd1;
          state_next = (cnt_reg == 16'd1) ? S_CSUM : S_DATA_HI;
        end
        S_CSUM: begin
          if (bus.rx_data == sum_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
            pause_next = 1'b0;
          end else begin
            state_next = S_ERR;
            err_next   = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end

    // An accepted byte always beats an expiring inter-byte timer.
    if (TIMEOUT_CYCLES != 0 && busy && !accept && tmo_reg == TMO_LAST) begin
      state_next = S_ERR;
      err_next   = 1'b1;
    end
  end

endmodule
